cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/run_budget_counter.sv | 33 +++
 rtl/cpu_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Brief    : Shared state encoding and default sizes for the CPU run control.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

   localparam int c_DEPTH_DEFAULT   = 8;
   localparam int c_LIMIT_W_DEFAULT = 8;
   localparam int c_ADDR_W          = 3;
   localparam int c_DATA_W          = 9;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_e;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/run_budget_counter.sv
`default_nettype none
// ============================================================================
//  Module   : run_budget_counter
//  Brief    : Saturating run-cycle counter with limit compare (0 = no limit).
//  Revision : 1.0  initial release
// ============================================================================
module run_budget_counter #(
   parameter int LIMIT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic [LIMIT_W-1:0] i_limit,
   output logic               o_hit
);

   logic [LIMIT_W-1:0] r_count;

   assign o_hit = (i_limit != '0) && (r_count == i_limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule : run_budget_counter
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Brief    : Host-side CPU controller: program load, run, single-step, halt.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DEPTH   = c_DEPTH_DEFAULT,
   parameter int LIMIT_W = c_LIMIT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic               run,
   input  logic               step,
   input  logic               halt_req,
   input  logic               ld_valid,
   input  logic [8:0]         ld_data,
   output logic               ld_ready,
   input  logic               bp_en,
   input  logic [2:0]         bp_addr,
   input  logic [2:0]         pc,
   input  logic [LIMIT_W-1:0] cycle_limit,
   output logic               pc_enable,
   output logic               ram_we,
   output logic [2:0]         ram_waddr,
   output logic [8:0]         ram_wdata,
   output logic               cpu_reset,
   output logic [2:0]         state,
   output logic               done,
   output logic               timeout
);

   localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(DEPTH - 1);

   state_e              r_state;
   logic [c_ADDR_W-1:0] r_addr;
   logic                r_ram_we;
   logic [c_ADDR_W-1:0] r_ram_waddr;
   logic [c_DATA_W-1:0] r_ram_wdata;
   logic                r_done;
   logic                r_timeout;
   logic                r_cpu_reset;
   logic                r_first;

   logic w_in_run;
   logic w_beat;
   logic w_bp_hit;
   logic w_bud_hit;
   logic w_pc_en;

   assign w_in_run = (r_state == ST_RUN);
   assign w_beat   = ld_valid & ld_ready;
   // The first cycle after (re)starting ignores the breakpoint so we can step off it.
   assign w_bp_hit = bp_en & (pc == bp_addr) & ~r_first;
   assign w_pc_en  = (w_in_run & ~halt_req & ~w_bp_hit & ~w_bud_hit) |
                     (r_state == ST_STEP);

   // Held clear outside RUN, so every RUN entry starts counting from zero.
   run_budget_counter #(
      .LIMIT_W (LIMIT_W)
   ) u_budget (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (~w_in_run),
      .i_enable (w_pc_en),
      .i_limit  (cycle_limit),
      .o_hit    (w_bud_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_ram_we    <= 1'b0;
         r_ram_waddr <= '0;
         r_ram_wdata <= '0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_cpu_reset <= 1'b1;
         r_first     <= 1'b0;
      end else begin
         r_ram_we    <= 1'b0;
         r_done      <= 1'b0;
         r_first     <= 1'b0;
         r_cpu_reset <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (load_start) begin
                  r_state     <= ST_LOAD;
                  r_addr      <= '0;
                  r_timeout   <= 1'b0;
                  r_cpu_reset <= 1'b1;
               end else if (!halt_req) begin
                  if (step) begin
                     r_state <= ST_STEP;
                     r_first <= 1'b1;
                  end else if (run) begin
                     r_state   <= ST_RUN;
                     r_first   <= 1'b1;
                     r_timeout <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               r_cpu_reset <= 1'b1;
               if (w_beat) begin
                  r_ram_we    <= 1'b1;
                  r_ram_waddr <= r_addr;
                  r_ram_wdata <= ld_data;
                  r_addr      <= r_addr + 1'b1;
               end
               if (load_start) begin
                  r_addr <= '0;
               end else if (halt_req) begin
                  r_state     <= ST_IDLE;
                  r_addr      <= '0;
                  r_cpu_reset <= 1'b0;
               end else if (w_beat && (r_addr == c_LAST_ADDR)) begin
                  // cpu_reset stays high through the done cycle, then drops.
                  r_state <= ST_IDLE;
                  r_addr  <= '0;
                  r_done  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (load_start) begin
                  r_state     <= ST_LOAD;
                  r_addr      <= '0;
                  r_timeout   <= 1'b0;
                  r_cpu_reset <= 1'b1;
               end else if (halt_req || w_bp_hit || w_bud_hit) begin
                  r_state <= ST_HALT;
                  if (w_bud_hit) begin
                     r_timeout <= 1'b1;
                  end
               end
            end
            ST_STEP: begin
               if (load_start) begin
                  r_state     <= ST_LOAD;
                  r_addr      <= '0;
                  r_timeout   <= 1'b0;
                  r_cpu_reset <= 1'b1;
               end else begin
                  r_state <= ST_HALT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ld_ready  = (r_state == ST_LOAD);
   assign pc_enable = w_pc_en;
   assign ram_we    = r_ram_we;
   assign ram_waddr = r_ram_waddr;
   assign ram_wdata = r_ram_wdata;
   assign cpu_reset = r_cpu_reset;
   assign state     = r_state;
   assign done      = r_done;
   assign timeout   = r_timeout;

endmodule : cpu_run_ctrl
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Brief    : Directed self-checking bench with RAM and PC models around the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_ctrl;

   logic       clk;
   logic       reset_n;
   logic       load_start, run, step, halt_req;
   logic       ld_valid;
   logic [8:0] ld_data;
   logic       ld_ready;
   logic       bp_en;
   logic [2:0] bp_addr;
   logic [2:0] pc_q;
   logic [7:0] cycle_limit;
   logic       pc_enable;
   logic       ram_we;
   logic [2:0] ram_waddr;
   logic [8:0] ram_wdata;
   logic       cpu_reset;
   logic [2:0] state;
   logic       done;
   logic       timeout;

   logic [8:0] ram [8];
   int         checks   = 0;
   int         errors   = 0;
   int         done_cnt = 0;
   int         en_cnt;

   cpu_run_ctrl #(
      .DEPTH   (8),
      .LIMIT_W (8)
   ) dut (
      .clk         (clk),
      .reset       (reset_n),
      .load_start  (load_start),
      .run         (run),
      .step        (step),
      .halt_req    (halt_req),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc          (pc_q),
      .cycle_limit (cycle_limit),
      .pc_enable   (pc_enable),
      .ram_we      (ram_we),
      .ram_waddr   (ram_waddr),
      .ram_wdata   (ram_wdata),
      .cpu_reset   (cpu_reset),
      .state       (state),
      .done        (done),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External program RAM and a minimal CPU whose PC advances on pc_enable.
   always @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      if (cpu_reset) pc_q <= 3'd0;
      else if (pc_enable) pc_q <= pc_q + 3'd1;
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; load_start = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
      ld_valid = 1'b0; ld_data = 9'd0; bp_en = 1'b0; bp_addr = 3'd0; cycle_limit = 8'd0;

      // Reset values
      tick(); tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc_enable", 32'(pc_enable), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_waddr", 32'(ram_waddr), 32'd0);
      check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      reset_n = 1'b1;
      tick();
      check("rel_cpu_reset", 32'(cpu_reset), 32'd0);

      // Program load with a two-cycle ld_valid gap before beat 3
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("load_state", 32'(state), 32'd1);
      check("load_ld_ready", 32'(ld_ready), 32'd1);
      check("load_cpu_reset", 32'(cpu_reset), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            ld_valid = 1'b0;
            tick();
            check("gap_we_a", 32'(ram_we), 32'd0);
            tick();
            check("gap_we_b", 32'(ram_we), 32'd0);
         end
         ld_valid = 1'b1;
         ld_data  = 9'(32'h1A0 + i);
         tick();
         check("beat_we", 32'(ram_we), 32'd1);
         check("beat_waddr", 32'(ram_waddr), 32'(i));
         check("beat_wdata", 32'(ram_wdata), 32'h1A0 + 32'(i));
      end
      ld_valid = 1'b0;
      check("end_done", 32'(done), 32'd1);
      check("end_state", 32'(state), 32'd0);
      check("end_ld_ready", 32'(ld_ready), 32'd0);
      check("end_cpu_reset_hold", 32'(cpu_reset), 32'd1);
      tick();
      check("post_done", 32'(done), 32'd0);
      check("post_cpu_reset", 32'(cpu_reset), 32'd0);
      check("post_ram_we", 32'(ram_we), 32'd0);
      for (int i = 0; i < 8; i++) check("ram_row", 32'(ram[i]), 32'h1A0 + 32'(i));
      check("done_pulses", 32'(done_cnt), 32'd1);

      // Breakpoint at address 5, unlimited budget
      bp_en = 1'b1; bp_addr = 3'd5; cycle_limit = 8'd0;
      run = 1'b1;
      tick();
      run = 1'b0;
      en_cnt = 0;
      for (int k = 0; k < 20 && state == 3'd2; k++) begin
         if (pc_enable) en_cnt++;
         tick();
      end
      check("bp_en_cycles", 32'(en_cnt), 32'd5);
      check("bp_state", 32'(state), 32'd4);
      check("bp_pc", 32'(pc_q), 32'd5);
      run = 1'b1;
      tick();
      run = 1'b0;
      check("resume_pc_enable", 32'(pc_enable), 32'd1);
      tick();
      check("resume_pc", 32'(pc_q), 32'd6);

      // halt_req together with run while running
      halt_req = 1'b1; run = 1'b1;
      #1;
      check("halt_pc_enable", 32'(pc_enable), 32'd0);
      tick();
      halt_req = 1'b0; run = 1'b0;
      check("halt_state", 32'(state), 32'd4);
      check("halt_pc", 32'(pc_q), 32'd6);

      // Run budget of 3 cycles
      bp_en = 1'b0; cycle_limit = 8'd3;
      run = 1'b1;
      tick();
      run = 1'b0;
      en_cnt = 0;
      for (int k = 0; k < 20 && state == 3'd2; k++) begin
         if (pc_enable) en_cnt++;
         tick();
      end
      check("budget_en_cycles", 32'(en_cnt), 32'd3);
      check("budget_state", 32'(state), 32'd4);
      check("budget_timeout", 32'(timeout), 32'd1);
      check("budget_pc", 32'(pc_q), 32'd1);
      run = 1'b1;
      tick();
      run = 1'b0;
      check("rerun_state", 32'(state), 32'd2);
      check("rerun_timeout", 32'(timeout), 32'd0);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("rerun_halt_state", 32'(state), 32'd4);
      check("rerun_halt_pc", 32'(pc_q), 32'd1);

      // Three single steps
      cycle_limit = 8'd0;
      for (int s = 0; s < 3; s++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         check("step_state", 32'(state), 32'd3);
         check("step_pc_enable", 32'(pc_enable), 32'd1);
         tick();
         check("step_back_state", 32'(state), 32'd4);
         check("step_off_enable", 32'(pc_enable), 32'd0);
         check("step_pc", 32'(pc_q), 32'd2 + 32'(s));
      end

      // Reset in the middle of a load, then a fresh load
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = 9'(32'h055 + i);
         tick();
      end
      ld_valid = 1'b0;
      check("mid_we", 32'(ram_we), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mrst_state", 32'(state), 32'd0);
      check("mrst_ram_we", 32'(ram_we), 32'd0);
      check("mrst_ram_waddr", 32'(ram_waddr), 32'd0);
      check("mrst_ram_wdata", 32'(ram_wdata), 32'd0);
      check("mrst_ld_ready", 32'(ld_ready), 32'd0);
      check("mrst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("mrst_pc_enable", 32'(pc_enable), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("mrel_cpu_reset", 32'(cpu_reset), 32'd0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      ld_valid = 1'b1; ld_data = 9'h0AA;
      tick();
      ld_valid = 1'b0;
      check("reload_we", 32'(ram_we), 32'd1);
      check("reload_waddr", 32'(ram_waddr), 32'd0);
      check("reload_wdata", 32'(ram_wdata), 32'h0AA);

      // halt_req aborts the load without a done pulse
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("abort_state", 32'(state), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      tick();
      check("abort_done_total", 32'(done_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_cpu_run_ctrl
`default_nettype wire
